// File: rtl/cam_msg_ctrl.sv
// cam_msg_ctrl: circular FIX tag store with an in-order queue of completed
// message descriptors and a one-cycle-latency CAM search over the oldest
// completed message. Entries are reclaimed only when the downstream field
// extractor releases the head message.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   wr_en_i, data_i       tag word write (dropped when the store is full)
//   start_message_i       open a message at the current write pointer
//   end_message_i         close the open message (includes this cycle's write)
//   search_i, find_tag_i  search the head message for find_tag_i
//   release_i             pop the head descriptor and free its entries
//   msg_valid_o/start/len head descriptor
//   search_done_o, tag_match_o, index_value_o  registered search result
//   full_o, empty_o       store occupancy flags
//   overflow_o            pulse: write dropped because the store was full
//   msg_drop_o            pulse: completed message lost, descriptor queue full
module cam_msg_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int MSG_SLOTS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  start_message_i,
  input  logic                  end_message_i,
  input  logic                  search_i,
  input  logic [DATA_WIDTH-1:0] find_tag_i,
  input  logic                  release_i,
  output logic                  msg_valid_o,
  output logic [ADDR_WIDTH-1:0] msg_start_o,
  output logic [ADDR_WIDTH:0]   msg_len_o,
  output logic                  search_done_o,
  output logic                  tag_match_o,
  output logic [ADDR_WIDTH-1:0] index_value_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  overflow_o,
  output logic                  msg_drop_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int QW    = $clog2(MSG_SLOTS);

  // Pointers carry a wrap bit so DEPTH entries and 0 entries are distinct.
  typedef logic [ADDR_WIDTH:0] ptr_t;
  typedef logic [QW:0]         qcnt_t;
  typedef struct packed {
    ptr_t start;
    ptr_t len;
  } desc_t;
  typedef enum logic {IDLE, IN_MSG} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  desc_t                 q   [MSG_SLOTS];

  ptr_t            wr_ptr, rd_ptr, cur_start, count, new_len;
  state_t          state;
  logic [QW-1:0]   q_head, q_tail;
  qcnt_t           q_cnt;
  desc_t           head;
  logic            q_valid, q_full, wr_acc, rel, closing, push_req, push, drop;
  logic            hit;
  logic [ADDR_WIDTH-1:0] hit_addr;

  assign count    = wr_ptr - rd_ptr;
  assign full_o   = (count == ptr_t'(DEPTH));
  assign empty_o  = (count == '0);
  assign head     = q[q_head];
  assign q_valid  = (q_cnt != '0);
  assign q_full   = (q_cnt == qcnt_t'(MSG_SLOTS));
  assign wr_acc   = wr_en_i && !full_o;
  assign rel      = release_i && q_valid;
  assign closing  = end_message_i && (state == IN_MSG);
  assign new_len  = wr_ptr + ptr_t'(wr_acc) - cur_start;
  assign push_req = closing && (new_len != '0);
  // A same-cycle release frees a slot, so a full queue can still accept.
  assign drop     = push_req && q_full && !rel;
  assign push     = push_req && !drop;

  assign msg_valid_o = q_valid;
  assign msg_start_o = q_valid ? head.start[ADDR_WIDTH-1:0] : '0;
  assign msg_len_o   = q_valid ? head.len : '0;

  // Scan from the highest offset down so the lowest-offset match wins.
  always_comb begin
    hit      = 1'b0;
    hit_addr = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((ptr_t'(i) < head.len) &&
          (mem[head.start[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i)] == find_tag_i)) begin
        hit      = 1'b1;
        hit_addr = head.start[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i);
      end
    end
  end

  // Storage arrays carry no reset; pointers and counts define what is live.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_i;
    if (push)   q[q_tail] <= '{start: cur_start, len: new_len};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cur_start     <= '0;
      state         <= IDLE;
      q_head        <= '0;
      q_tail        <= '0;
      q_cnt         <= '0;
      search_done_o <= 1'b0;
      tag_match_o   <= 1'b0;
      index_value_o <= '0;
      overflow_o    <= 1'b0;
      msg_drop_o    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      // Jumping to the end of the head message also frees leading orphans.
      if (rel) begin
        rd_ptr <= head.start + head.len;
        q_head <= q_head + 1'b1;
      end
      if (push) q_tail <= q_tail + 1'b1;
      if (push && !rel)      q_cnt <= q_cnt + 1'b1;
      else if (rel && !push) q_cnt <= q_cnt - 1'b1;

      // End closes the current message before a same-cycle start reopens
      // one after this cycle's write.
      if (start_message_i) begin
        state     <= IN_MSG;
        cur_start <= closing ? wr_ptr + ptr_t'(wr_acc) : wr_ptr;
      end else if (closing) begin
        state     <= IDLE;
      end

      search_done_o <= search_i;
      if (search_i) begin
        tag_match_o   <= q_valid && hit;
        index_value_o <= (q_valid && hit) ? hit_addr : '0;
      end
      overflow_o <= wr_en_i && full_o;
      msg_drop_o <= drop;
    end
  end
endmodule

// File: tb/tb_cam_msg_ctrl.sv
// Testbench for cam_msg_ctrl (ADDR_WIDTH=3, MSG_SLOTS=4). Directed scenarios
// check fixed expected values; a randomized run checks every output against a
// reference model built from absolute write/read counts and a queue of
// {start, len} messages.
module tb_cam_msg_ctrl;
  localparam int DW = 32, AW = 3, SL = 4, DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, wr_en_i, start_message_i, end_message_i, search_i, release_i;
  logic [DW-1:0] data_i, find_tag_i;
  logic          msg_valid_o, search_done_o, tag_match_o, full_o, empty_o, overflow_o, msg_drop_o;
  logic [AW-1:0] msg_start_o, index_value_o;
  logic [AW:0]   msg_len_o;

  cam_msg_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MSG_SLOTS(SL)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en_i), .data_i(data_i),
    .start_message_i(start_message_i), .end_message_i(end_message_i),
    .search_i(search_i), .find_tag_i(find_tag_i), .release_i(release_i),
    .msg_valid_o(msg_valid_o), .msg_start_o(msg_start_o), .msg_len_o(msg_len_o),
    .search_done_o(search_done_o), .tag_match_o(tag_match_o),
    .index_value_o(index_value_o), .full_o(full_o), .empty_o(empty_o),
    .overflow_o(overflow_o), .msg_drop_o(msg_drop_o)
  );

  int checks = 0, failures = 0;

  // Reference model: absolute counters, plain array store, message queue.
  int            m_wr, m_rd, m_cur;
  bit            m_in;
  logic [DW-1:0] m_mem [DEPTH];
  int            q_start[$], q_len[$];
  logic          e_done, e_match, e_ovf, e_drop;
  logic [AW-1:0] e_idx;

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_cur = 0; m_in = 0;
    q_start.delete(); q_len.delete();
    e_done = 0; e_match = 0; e_idx = '0; e_ovf = 0; e_drop = 0;
  endtask

  task automatic model_step(input logic wr, input logic [DW-1:0] d, input logic st,
                            input logic en, input logic sr, input logic [DW-1:0] key,
                            input logic rl);
    bit full, acc, rl_ok, ended;
    int len, a;
    full  = ((m_wr - m_rd) == DEPTH);
    acc   = wr && !full;
    rl_ok = rl && (q_start.size() > 0);
    ended = 0;
    e_done = sr;
    if (sr) begin
      e_match = 0; e_idx = '0;
      if (q_start.size() > 0)
        for (int o = 0; o < q_len[0]; o++) begin
          a = (q_start[0] + o) % DEPTH;
          if (m_mem[a] == key) begin e_match = 1; e_idx = AW'(a); break; end
        end
    end
    e_ovf  = wr && full;
    e_drop = 0;
    if (en && m_in) begin
      len = m_wr + int'(acc) - m_cur;
      ended = 1; m_in = 0;
      if (len > 0) begin
        if (q_start.size() == SL && !rl_ok) e_drop = 1;
        else begin q_start.push_back(m_cur); q_len.push_back(len); end
      end
    end
    if (st) begin m_cur = ended ? m_wr + int'(acc) : m_wr; m_in = 1; end
    if (acc) begin m_mem[m_wr % DEPTH] = d; m_wr++; end
    if (rl_ok) begin
      m_rd = q_start[0] + q_len[0];
      void'(q_start.pop_front()); void'(q_len.pop_front());
    end
  endtask

  task automatic cycle(input logic wr, input logic [DW-1:0] d, input logic st,
                       input logic en, input logic sr, input logic [DW-1:0] key,
                       input logic rl);
    @(negedge clk);
    wr_en_i = wr; data_i = d; start_message_i = st; end_message_i = en;
    search_i = sr; find_tag_i = key; release_i = rl;
    @(posedge clk);
    model_step(wr, d, st, en, sr, key, rl);
    #1;
    wr_en_i = 0; start_message_i = 0; end_message_i = 0; search_i = 0; release_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; wr_en_i = 0; start_message_i = 0; end_message_i = 0;
    search_i = 0; release_i = 0; data_i = '0; find_tag_i = '0;
    @(posedge clk);
    model_reset();
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (msg_valid_o !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%b exp=0", msg_valid_o); end
    if (empty_o !== 1'b1)      begin failures++; $display("FAIL reset_empty got=%b exp=1", empty_o); end
    if (full_o !== 1'b0)       begin failures++; $display("FAIL reset_full got=%b exp=0", full_o); end
    if (search_done_o !== 1'b0 || tag_match_o !== 1'b0 || index_value_o !== '0)
      begin failures++; $display("FAIL reset_search got=%b/%b/%0d exp=0/0/0", search_done_o, tag_match_o, index_value_o); end
    if (overflow_o !== 1'b0 || msg_drop_o !== 1'b0)
      begin failures++; $display("FAIL reset_pulses got=%b/%b exp=0/0", overflow_o, msg_drop_o); end
    if (msg_start_o !== '0 || msg_len_o !== '0)
      begin failures++; $display("FAIL reset_desc got=%0d/%0d exp=0/0", msg_start_o, msg_len_o); end
  endtask

  task automatic test_basic();
    do_reset();
    cycle(1, 32'h23, 1, 0, 0, 0, 0);
    cycle(1, 32'h08, 0, 0, 0, 0, 0);
    cycle(1, 32'h09, 0, 1, 0, 0, 0);
    checks++;
    if (msg_valid_o !== 1'b1 || msg_start_o !== 3'd0 || msg_len_o !== 4'd3)
      begin failures++; $display("FAIL basic_desc got=%b/%0d/%0d exp=1/0/3", msg_valid_o, msg_start_o, msg_len_o); end
    cycle(0, 0, 0, 0, 1, 32'h08, 0);
    checks++;
    if (search_done_o !== 1'b1 || tag_match_o !== 1'b1 || index_value_o !== 3'd1)
      begin failures++; $display("FAIL basic_search got=%b/%b/%0d exp=1/1/1", search_done_o, tag_match_o, index_value_o); end
  endtask

  task automatic test_scope();
    do_reset();
    cycle(1, 32'h10, 1, 0, 0, 0, 0);
    cycle(1, 32'h11, 0, 1, 0, 0, 0);
    cycle(1, 32'h12, 1, 0, 0, 0, 0);
    cycle(0, 0,      0, 1, 0, 0, 0);
    cycle(0, 0,      0, 0, 1, 32'h12, 0);
    checks++;
    if (search_done_o !== 1'b1 || tag_match_o !== 1'b0)
      begin failures++; $display("FAIL scope_head_a got=%b/%b exp=1/0", search_done_o, tag_match_o); end
    cycle(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (msg_start_o !== 3'd2 || msg_len_o !== 4'd1)
      begin failures++; $display("FAIL scope_head_b got=%0d/%0d exp=2/1", msg_start_o, msg_len_o); end
    cycle(0, 0, 0, 0, 1, 32'h12, 0);
    checks++;
    if (tag_match_o !== 1'b1 || index_value_o !== 3'd2)
      begin failures++; $display("FAIL scope_search_b got=%b/%0d exp=1/2", tag_match_o, index_value_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, 32'h40 + i, i == 0, i == 5, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (empty_o !== 1'b1 || msg_valid_o !== 1'b0)
      begin failures++; $display("FAIL wrap_release got=%b/%b exp=1/0", empty_o, msg_valid_o); end
    for (int i = 0; i < 5; i++) begin
      cycle(1, 32'h50 + i, i == 0, i == 4, 0, 0, 0);
      checks++;
      if (full_o !== 1'b0) begin failures++; $display("FAIL wrap_full got=%b exp=0 step=%0d", full_o, i); end
    end
    checks++;
    if (msg_start_o !== 3'd6 || msg_len_o !== 4'd5)
      begin failures++; $display("FAIL wrap_desc got=%0d/%0d exp=6/5", msg_start_o, msg_len_o); end
    cycle(0, 0, 0, 0, 1, 32'h53, 0);
    checks++;
    if (tag_match_o !== 1'b1 || index_value_o !== 3'd1)
      begin failures++; $display("FAIL wrap_search got=%b/%0d exp=1/1", tag_match_o, index_value_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 32'h60 + i, i == 0, i == 7, 0, 0, 0);
    checks++;
    if (full_o !== 1'b1 || overflow_o !== 1'b0)
      begin failures++; $display("FAIL ovf_full got=%b/%b exp=1/0", full_o, overflow_o); end
    cycle(1, 32'h99, 0, 0, 0, 0, 0);
    checks++;
    if (overflow_o !== 1'b1 || full_o !== 1'b1)
      begin failures++; $display("FAIL ovf_pulse got=%b/%b exp=1/1", overflow_o, full_o); end
    cycle(0, 0, 0, 0, 1, 32'h99, 0);
    checks++;
    if (overflow_o !== 1'b0 || tag_match_o !== 1'b0)
      begin failures++; $display("FAIL ovf_dropped got=%b/%b exp=0/0", overflow_o, tag_match_o); end
    cycle(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (empty_o !== 1'b1 || full_o !== 1'b0)
      begin failures++; $display("FAIL ovf_wrptr got=%b/%b exp=1/0", empty_o, full_o); end
  endtask

  task automatic test_queue_full();
    do_reset();
    for (int m = 0; m < 5; m++) begin
      cycle(1, 32'h30 + m, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0, 0);
      checks++;
      if (msg_drop_o !== (m == 4))
        begin failures++; $display("FAIL qfull_drop got=%b exp=%b msg=%0d", msg_drop_o, m == 4, m); end
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (msg_drop_o !== 1'b0 || msg_start_o !== 3'd0 || msg_valid_o !== 1'b1)
      begin failures++; $display("FAIL qfull_after got=%b/%0d/%b exp=0/0/1", msg_drop_o, msg_start_o, msg_valid_o); end
    do_reset();
    for (int m = 0; m < 4; m++) begin
      cycle(1, 32'h30 + m, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0, 0);
    end
    cycle(1, 32'h34, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 1);
    checks++;
    if (msg_drop_o !== 1'b0 || msg_start_o !== 3'd1)
      begin failures++; $display("FAIL qfull_rel got=%b/%0d exp=0/1", msg_drop_o, msg_start_o); end
    for (int r = 0; r < 3; r++) cycle(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (msg_valid_o !== 1'b1 || msg_start_o !== 3'd4 || msg_len_o !== 4'd1)
      begin failures++; $display("FAIL qfull_fifth got=%b/%0d/%0d exp=1/4/1", msg_valid_o, msg_start_o, msg_len_o); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] keys [5];
    logic          em [5];
    logic [AW-1:0] ei [5];
    keys = '{32'hA3, 32'hA0, 32'hA2, 32'h77, 32'hA1};
    em   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    ei   = '{3'd3, 3'd0, 3'd2, 3'd0, 3'd1};
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 32'hA0 + i, i == 0, i == 3, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 1, keys[i], 0);
      checks++;
      if (search_done_o !== 1'b1 || tag_match_o !== em[i] || index_value_o !== ei[i])
        begin failures++; $display("FAIL b2b_search%0d got=%b/%b/%0d exp=1/%b/%0d", i, search_done_o, tag_match_o, index_value_o, em[i], ei[i]); end
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (search_done_o !== 1'b0 || tag_match_o !== 1'b1 || index_value_o !== 3'd1)
      begin failures++; $display("FAIL b2b_hold got=%b/%b/%0d exp=0/1/1", search_done_o, tag_match_o, index_value_o); end
  endtask

  task automatic test_reset_mid_search();
    do_reset();
    cycle(1, 32'h23, 1, 0, 0, 0, 0);
    cycle(1, 32'h08, 0, 1, 0, 0, 0);
    @(negedge clk);
    search_i = 1; find_tag_i = 32'h08; rst_n = 0;
    @(posedge clk);
    model_reset();
    #1;
    checks++;
    if (search_done_o !== 1'b0 || empty_o !== 1'b1 || msg_valid_o !== 1'b0)
      begin failures++; $display("FAIL rstsrch_edge got=%b/%b/%b exp=0/1/0", search_done_o, empty_o, msg_valid_o); end
    rst_n = 1; search_i = 0;
    cycle(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (search_done_o !== 1'b0 || tag_match_o !== 1'b0)
      begin failures++; $display("FAIL rstsrch_after got=%b/%b exp=0/0", search_done_o, tag_match_o); end
  endtask

  task automatic test_random();
    logic          e_valid;
    logic [AW-1:0] e_start;
    logic [AW:0]   e_len;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (n % 300 == 299) do_reset();
      cycle($urandom_range(0, 9) < 6, DW'($urandom_range(0, 5)), $urandom_range(0, 9) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, DW'($urandom_range(0, 5)),
            $urandom_range(0, 7) == 0);
      e_valid = q_start.size() > 0;
      e_start = e_valid ? AW'(q_start[0] % DEPTH) : '0;
      e_len   = e_valid ? (AW+1)'(q_len[0]) : '0;
      checks++;
      if (msg_valid_o !== e_valid || msg_start_o !== e_start || msg_len_o !== e_len)
        begin failures++; $display("FAIL rnd_desc n=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", n, msg_valid_o, msg_start_o, msg_len_o, e_valid, e_start, e_len); end
      checks++;
      if (full_o !== ((m_wr - m_rd) == DEPTH) || empty_o !== (m_wr == m_rd))
        begin failures++; $display("FAIL rnd_flags n=%0d got=%b/%b exp=%b/%b", n, full_o, empty_o, (m_wr - m_rd) == DEPTH, m_wr == m_rd); end
      checks++;
      if (search_done_o !== e_done || tag_match_o !== e_match || index_value_o !== e_idx)
        begin failures++; $display("FAIL rnd_search n=%0d got=%b/%b/%0d exp=%b/%b/%0d", n, search_done_o, tag_match_o, index_value_o, e_done, e_match, e_idx); end
      checks++;
      if (overflow_o !== e_ovf || msg_drop_o !== e_drop)
        begin failures++; $display("FAIL rnd_pulses n=%0d got=%b/%b exp=%b/%b", n, overflow_o, msg_drop_o, e_ovf, e_drop); end
    end
  endtask

  initial begin
    rst_n = 0; wr_en_i = 0; data_i = '0; start_message_i = 0; end_message_i = 0;
    search_i = 0; find_tag_i = '0; release_i = 0;
    model_reset();
    test_reset();
    test_basic();
    test_scope();
    test_wrap();
    test_overflow();
    test_queue_full();
    test_back_to_back();
    test_reset_mid_search();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
